// File: rtl/stage_if_fetch_queue.sv
// Instruction-fetch stage with a prefetching PC generator, a synchronous IMEM
// request/response pipe and a decoupling FIFO of {pc, npc, instr} entries.
// Requests are credit-limited so every response always has a free FIFO slot.
// A redirect flushes the FIFO and the in-flight request, then refetches from
// the target.
//
// Handshake: an entry leaves the FIFO on a rising edge where out_valid_o and
// out_ready_i are both high; while out_valid_o && !out_ready_i the head
// outputs (pc_o, npc_o, instruction_o) hold their values.
module stage_if_fetch_queue #(
    parameter int          IMEM_AW  = 11,
    parameter int          FQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        redirect_i,
    input  logic [31:0]                 redirect_pc_i,
    input  logic                        out_ready_i,
    output logic                        out_valid_o,
    output logic [31:0]                 pc_o,
    output logic [31:0]                 npc_o,
    output logic [31:0]                 instruction_o,
    output logic                        imem_en_o,
    output logic [IMEM_AW-1:0]          imem_addr_o,
    input  logic [31:0]                 imem_data_i,
    output logic [$clog2(FQ_DEPTH):0]   fq_count_o
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FQ_DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          infl_valid_q;
    logic [31:0]   infl_pc_q;
    logic [31:0]   pc_mem_q    [FQ_DEPTH];
    logic [31:0]   npc_mem_q   [FQ_DEPTH];
    logic [31:0]   instr_mem_q [FQ_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          issue;
    logic          push;
    logic          pop;
    logic [CW:0]   credits_used;
    logic          unused_pc_lsbs;

    // The two low bits of a redirect target are always discarded.
    assign unused_pc_lsbs = ^redirect_pc_i[1:0];

    // A credit is held by every queued entry and by the request in flight;
    // no request goes out during reset or in a redirect cycle.
    assign credits_used = {1'b0, count_q} + {{CW{1'b0}}, infl_valid_q};
    assign issue        = !rst_i && !redirect_i && (credits_used < DEPTH_C);
    assign push         = infl_valid_q && !redirect_i;
    assign pop          = (count_q != '0) && out_ready_i;

    assign imem_en_o     = issue;
    assign imem_addr_o   = fetch_pc_q[IMEM_AW+1:2];
    assign out_valid_o   = (count_q != '0);
    assign pc_o          = pc_mem_q[rd_ptr_q];
    assign npc_o         = npc_mem_q[rd_ptr_q];
    assign instruction_o = instr_mem_q[rd_ptr_q];
    assign fq_count_o    = count_q;

    // Next PC, pointers and occupancy; a redirect overrides everything else.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
            if (push)  wr_ptr_d   = wr_ptr_q + PW'(1);
            if (pop)   rd_ptr_d   = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // PC generator, FIFO pointers and count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Remember which PC the outstanding IMEM request belongs to.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            infl_valid_q <= 1'b0;
            infl_pc_q    <= '0;
        end else begin
            infl_valid_q <= issue;
            if (issue) infl_pc_q <= fetch_pc_q;
        end
    end

    // FIFO storage: the IMEM response is written at the tail with its PCs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                npc_mem_q[i]   <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]    <= infl_pc_q;
            npc_mem_q[wr_ptr_q]   <= infl_pc_q + 32'd4;
            instr_mem_q[wr_ptr_q] <= imem_data_i;
        end
    end

endmodule

// File: tb/tb_stage_if_fetch_queue.sv
// Bench for stage_if_fetch_queue: directed phases push the expected PC stream
// into a queue, a negedge monitor pops and compares every delivered entry.
module tb_stage_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        out_ready_i;
    logic        out_valid_o;
    logic [31:0] pc_o;
    logic [31:0] npc_o;
    logic [31:0] instruction_o;
    logic        imem_en_o;
    logic [10:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic [2:0]  fq_count_o;

    logic [31:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    bit          auto_ready = 1'b0;

    // Hold tracking for the head-stability check.
    bit          hold_q = 1'b0;
    logic [31:0] hold_pc, hold_npc, hold_instr;

    stage_if_fetch_queue #(
        .IMEM_AW (11),
        .FQ_DEPTH(4),
        .RESET_PC(32'h0)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .out_ready_i  (out_ready_i),
        .out_valid_o  (out_valid_o),
        .pc_o         (pc_o),
        .npc_o        (npc_o),
        .instruction_o(instruction_o),
        .imem_en_o    (imem_en_o),
        .imem_addr_o  (imem_addr_o),
        .imem_data_i  (imem_data_i),
        .fq_count_o   (fq_count_o)
    );

    // Clock
    always #5 clk = ~clk;

    // Synchronous ROM with ROM[i] = i.
    always @(posedge clk) begin
        if (imem_en_o) imem_data_i <= {21'b0, imem_addr_o};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_i) begin
            if (hold_q) begin
                check("hold_valid", {31'b0, out_valid_o}, 32'd1);
                check("hold_pc", pc_o, hold_pc);
                check("hold_npc", npc_o, hold_npc);
                check("hold_instr", instruction_o, hold_instr);
            end
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_delivery: got pc %h expected none", pc_o);
                end else begin
                    logic [31:0] e;
                    logic [31:0] e_instr;
                    e = exp_q.pop_front();
                    e_instr = {21'b0, e[12:2]};
                    check("deliv_pc", pc_o, e);
                    check("deliv_npc", npc_o, e + 32'd4);
                    check("deliv_instr", instruction_o, e_instr);
                end
            end
            hold_q     = out_valid_o && !out_ready_i && !redirect_i;
            hold_pc    = pc_o;
            hold_npc   = npc_o;
            hold_instr = instruction_o;
        end else begin
            hold_q = 1'b0;
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
        if (auto_ready) out_ready_i = (exp_q.size() != 0);
    endtask

    task automatic push_stream(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(4 * i));
    endtask

    task automatic drain(input string name, input int exp_n);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        check(name, n, exp_n);
    endtask

    // Reset asserted between edges; outputs must clear immediately.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_i      = 1'b1;
        redirect_i = 1'b0;
        #1;
        check("rst_valid", {31'b0, out_valid_o}, 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_npc", npc_o, 32'd0);
        check("rst_instr", instruction_o, 32'd0);
        check("rst_count", {29'b0, fq_count_o}, 32'd0);
        check("rst_en", {31'b0, imem_en_o}, 32'd0);
        exp_q.delete();
        auto_ready  = 1'b0;
        out_ready_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] tgt, input logic [31:0] first, input int n);
        redirect_i    = 1'b1;
        redirect_pc_i = tgt;
        @(negedge clk);
        #1;
        exp_q.delete();
        push_stream(first, n);
        step();
        redirect_i = 1'b0;
    endtask

    initial begin
        rst_i         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        out_ready_i   = 1'b0;
        imem_data_i   = 32'h0;

        // Phase 1: reset release, streaming from RESET_PC.
        async_reset();
        push_stream(32'h0, 3);
        auto_ready  = 1'b1;
        out_ready_i = 1'b1;
        @(negedge clk); #1;
        check("p1_c0_en", {31'b0, imem_en_o}, 32'd1);
        check("p1_c0_addr", {21'b0, imem_addr_o}, 32'd0);
        check("p1_c0_valid", {31'b0, out_valid_o}, 32'd0);
        step();
        @(negedge clk); #1;
        check("p1_c1_addr", {21'b0, imem_addr_o}, 32'd1);
        check("p1_c1_valid", {31'b0, out_valid_o}, 32'd0);
        step();
        @(negedge clk); #1;
        check("p1_c2_valid", {31'b0, out_valid_o}, 32'd1);
        drain("p1_drain", 3);

        // Phase 2: stall for 10 cycles, then contiguous release.
        async_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (c == 4) begin
                check("p2_c4_count", {29'b0, fq_count_o}, 32'd3);
                check("p2_c4_en", {31'b0, imem_en_o}, 32'd0);
            end
            if (c == 9) begin
                check("p2_full_count", {29'b0, fq_count_o}, 32'd4);
                check("p2_full_en", {31'b0, imem_en_o}, 32'd0);
                check("p2_full_valid", {31'b0, out_valid_o}, 32'd1);
                check("p2_full_pc", pc_o, 32'h0);
            end
            if (c < 9) step();
        end
        push_stream(32'h0, 8);
        auto_ready = 1'b1;
        drain("p2_contiguous", 9);

        // Phase 3: redirect with 3 queued and 1 in flight.
        async_reset();
        repeat (4) step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        @(negedge clk); #1;
        check("p3_pre_count", {29'b0, fq_count_o}, 32'd3);
        check("p3_redir_en", {31'b0, imem_en_o}, 32'd0);
        push_stream(32'h100, 4);
        step();
        redirect_i = 1'b0;
        @(negedge clk); #1;
        check("p3_flush_count", {29'b0, fq_count_o}, 32'd0);
        check("p3_flush_valid", {31'b0, out_valid_o}, 32'd0);
        check("p3_target_en", {31'b0, imem_en_o}, 32'd1);
        check("p3_target_addr", {21'b0, imem_addr_o}, 32'd64);
        step();
        @(negedge clk); #1;
        check("p3_r2_valid", {31'b0, out_valid_o}, 32'd0);
        check("p3_r2_addr", {21'b0, imem_addr_o}, 32'd65);
        step();
        @(negedge clk); #1;
        check("p3_r3_valid", {31'b0, out_valid_o}, 32'd1);
        check("p3_r3_pc", pc_o, 32'h100);
        auto_ready = 1'b1;
        drain("p3_drain", 5);

        // Phase 4: misaligned target, then back-to-back redirects.
        redirect_to(32'h203, 32'h200, 2);
        drain("p4_align_drain", 4);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        step();
        redirect_to(32'h80, 32'h80, 3);
        drain("p4_b2b_drain", 5);

        // Phase 5: PC and ROM index wrap.
        redirect_to(32'hFFFF_FFFC, 32'hFFFF_FFFC, 3);
        drain("p5_wrap_drain", 5);

        // Phase 6: asynchronous reset mid-stream, restart at RESET_PC.
        async_reset();
        push_stream(32'h0, 4);
        auto_ready = 1'b1;
        drain("p6_restart_drain", 6);

        check("leftover_expected", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
